write_fsm: RTL and testbench

- Keypad-entry sequencer for the calculator datapath.
- Consumes classified key events (digit, register-select, operator), each qualified by a key strobe.
- Emits one-cycle command pulses: store a digit, latch a register number, or signal that both operands and the operator are ready for the ALU.
- Sits between the keypad decoder and the operand register file / result logic.

---
 rtl/write_fsm_pkg.sv | 13 +
 rtl/key_edge_detect.sv | 15 +
 rtl/write_fsm.sv | 43 ++++
 tb/tb_write_fsm.sv | 124 ++++++++++++
 4 files changed

// File: rtl/write_fsm_pkg.sv
// write_fsm_pkg: state encoding and reset state for the keypad-entry sequencer
package write_fsm_pkg;
  typedef enum logic [2:0] {
    IDLE1  = 3'd0,
    DIG1   = 3'd1,
    IDLE2  = 3'd2,
    DIG2   = 3'd3,
    IDLE3  = 3'd4,
    REG    = 3'd5,
    RESULT = 3'd6
  } state_t;
  localparam state_t RESET_STATE = IDLE1;
endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: rising-edge detector for the key strobe, built only with WRITE_FSM_STROBE_EDGE_EN
`ifdef WRITE_FSM_STROBE_EDGE_EN
module key_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);
  logic in_q;
  // previous strobe level, cleared in reset so a strobe high at release counts as an edge
  always_ff @(posedge clk)
    in_q <= rst ? in : 1'b0;
  assign rise = in & ~in_q;
endmodule
`endif

// File: rtl/write_fsm.sv
// write_fsm: keypad-entry sequencer (two digits, then register or operator); WRITE_FSM_STROBE_EDGE_EN selects edge-qualified strobe
module write_fsm
  import write_fsm_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic key_strobe,
  input  logic isop,
  input  logic isdig,
  input  logic isreg,
  output logic store_dig,
  output logic reg_num,
  output logic result_ready
);
  state_t state, next_state;
  logic ev;
`ifdef WRITE_FSM_STROBE_EDGE_EN
  key_edge_detect u_edge (.clk(clk), .rst(rst), .in(key_strobe), .rise(ev));
`else
  assign ev = key_strobe;
`endif
  // state register; active-low reset wins over any key event
  always_ff @(posedge clk)
    state <= rst ? next_state : RESET_STATE;
  // next state; digits outrank register keys, which outrank operators
  always_comb begin
    next_state = IDLE1;
    case (state)
      IDLE1:  next_state = (ev && isdig) ? DIG1 : IDLE1;
      DIG1:   next_state = IDLE2;
      IDLE2:  next_state = (ev && isdig) ? DIG2 : IDLE2;
      DIG2:   next_state = IDLE3;
      IDLE3:  next_state = (!ev || isdig) ? IDLE3 : isreg ? REG : isop ? RESULT : IDLE3;
      default: next_state = IDLE1;
    endcase
  end
  // Moore output decode; unused encodings give all zeros
  always_comb begin
    store_dig    = (state == DIG1) || (state == DIG2);
    reg_num      = state == REG;
    result_ready = state == RESULT;
  end
endmodule

// File: tb/tb_write_fsm.sv
// tb_write_fsm: directed and random key sequences checked against a digit-count model
module tb_write_fsm;
  import write_fsm_pkg::*;
  logic tb_clk = 1'b0;
  logic rst = 1'b0, key_strobe = 1'b0, isop = 1'b0, isdig = 1'b0, isreg = 1'b0;
  logic store_dig, reg_num, result_ready;
  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int m_pulse = 0;
  logic m_prev = 1'b0;
  always #5 tb_clk = ~tb_clk;
  write_fsm dut (
    .clk(tb_clk), .rst(rst), .key_strobe(key_strobe), .isop(isop), .isdig(isdig), .isreg(isreg),
    .store_dig(store_dig), .reg_num(reg_num), .result_ready(result_ready)
  );
  task automatic tick(input string tag, input logic r, input logic k, input logic o, input logic d, input logic g);
    logic ev;
    logic [2:0] exp;
    rst = r; key_strobe = k; isop = o; isdig = d; isreg = g;
    @(posedge tb_clk);
`ifdef WRITE_FSM_STROBE_EDGE_EN
    ev = k && !m_prev;
`else
    ev = k;
`endif
    m_prev = r ? k : 1'b0;
    if (!r) begin
      m_cnt = 0;
      m_pulse = 0;
    end else if (m_pulse != 0)
      m_pulse = 0;
    else if (ev) begin
      if (d) begin
        if (m_cnt < 2) begin
          m_cnt++;
          m_pulse = 1;
        end
      end else if (m_cnt == 2 && g) begin
        m_cnt = 0;
        m_pulse = 2;
      end else if (m_cnt == 2 && o) begin
        m_cnt = 0;
        m_pulse = 3;
      end
    end
    exp = (m_pulse == 1) ? 3'b100 : (m_pulse == 2) ? 3'b010 : (m_pulse == 3) ? 3'b001 : 3'b000;
    @(negedge tb_clk);
    checks++;
    assert ({store_dig, reg_num, result_ready} === exp) else begin
      failures++;
      $error("FAIL %s: outputs {store_dig,reg_num,result_ready}=%b expected %b", tag, {store_dig, reg_num, result_ready}, exp);
    end
  endtask
  initial begin
    @(negedge tb_clk);
    tick("reset0", 0, 1, 1, 1, 1);
    tick("reset1", 0, 1, 1, 1, 1);
    tick("idle_noflags", 1, 1, 0, 0, 0);
    checks++;
    assert (dut.state === IDLE1) else begin
      failures++;
      $error("FAIL reset_state: state=%0d expected %0d", dut.state, IDLE1);
    end
    tick("op1_dig1", 1, 1, 0, 1, 0);
    tick("op1_gap1", 1, 0, 0, 0, 0);
    tick("op1_dig2", 1, 1, 0, 1, 0);
    tick("op1_gap2", 1, 0, 0, 0, 0);
    tick("op1_reg", 1, 1, 0, 0, 1);
    tick("op1_back", 1, 0, 0, 0, 0);
    tick("ign_op_idle1", 1, 1, 1, 0, 0);
    tick("ign_reg_idle1", 1, 1, 0, 0, 1);
    tick("op2_dig1", 1, 1, 0, 1, 0);
    tick("op2_gap1", 1, 0, 0, 0, 0);
    tick("ign_op_idle2", 1, 1, 1, 0, 0);
    tick("ign_reg_idle2", 1, 1, 0, 0, 1);
    tick("op2_dig2", 1, 1, 0, 1, 0);
    tick("op2_gap2", 1, 0, 0, 0, 0);
    tick("third_dig", 1, 1, 0, 1, 0);
    tick("third_dig_after", 1, 0, 0, 0, 0);
    checks++;
    assert (dut.state === IDLE3) else begin
      failures++;
      $error("FAIL third_dig_state: state=%0d expected %0d", dut.state, IDLE3);
    end
    tick("dig_beats_op", 1, 1, 1, 1, 0);
    tick("reg_beats_op", 1, 1, 1, 0, 1);
    tick("reg_back", 1, 0, 0, 0, 0);
    tick("op3_dig1", 1, 1, 0, 1, 0);
    tick("op3_gap1", 1, 0, 0, 0, 0);
    tick("op3_dig2", 1, 1, 0, 1, 0);
    tick("op3_gap2", 1, 0, 0, 0, 0);
    tick("op3_op", 1, 1, 1, 0, 0);
    tick("op3_back", 1, 0, 0, 0, 0);
    tick("mid_dig", 1, 1, 0, 1, 0);
    tick("mid_gap", 1, 0, 0, 0, 0);
    tick("mid_reset", 0, 1, 0, 1, 0);
    tick("post_reset_dig", 1, 1, 0, 1, 0);
    tick("post_reset_gap", 1, 0, 0, 0, 0);
    tick("post_reset_op", 1, 1, 1, 0, 0);
    tick("post_reset_reg", 1, 1, 0, 0, 1);
    tick("post_reset_dig2", 1, 1, 0, 1, 0);
    tick("post_reset_gap2", 1, 0, 0, 0, 0);
    tick("post_reset_reg2", 1, 1, 0, 0, 1);
    tick("post_reset_back", 1, 0, 0, 0, 0);
    tick("nostrobe_dig", 1, 0, 0, 1, 0);
    tick("nostrobe_dig2", 1, 0, 0, 1, 0);
    tick("held_dig0", 1, 1, 0, 1, 0);
    tick("held_dig1", 1, 1, 0, 1, 0);
    tick("held_dig2", 1, 1, 0, 1, 0);
    tick("held_release", 1, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      tick("random", $urandom_range(0, 24) != 0, $urandom_range(0, 2) != 0,
           1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, 1'($urandom_range(0, 1)));
      checks++;
      assert ($onehot0({store_dig, reg_num, result_ready})) else begin
        failures++;
        $error("FAIL exclusive: outputs=%b expected at most one high", {store_dig, reg_num, result_ready});
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
